lc3_decode_stage: RTL



---
 rtl/lc3_pkg.sv | 15 +
 rtl/lc3_decode_ctrl.sv | 30 +++
 rtl/lc3_decode_stage.sv | 60 ++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// lc3_pkg: opcodes and control-word encodings shared by the decode stage and its agents
package lc3_pkg;
    localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100, OP_LEA = 4'b1110;
    typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_AND = 2'b01, ALU_NOT = 2'b10} alu_e;
    typedef enum logic [1:0] {PCS1_OFF11 = 2'b00, PCS1_OFF9 = 2'b01, PCS1_OFF6 = 2'b10, PCS1_ZERO = 2'b11} pcs1_e;
    typedef enum logic [1:0] {W_ALU = 2'b00, W_LEA = 2'b01, W_MEM = 2'b10} wsel_e;
    typedef struct packed {
        alu_e  alu;
        pcs1_e pcs1;
        logic  pcs2;
        logic  op2;
    } e_ctrl_t;
endpackage

// File: rtl/lc3_decode_ctrl.sv
// lc3_decode_ctrl: combinational opcode to execute/writeback/memory control words
module lc3_decode_ctrl
    import lc3_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic       imm_i,
    output logic [5:0] e_o,
    output logic [1:0] w_o,
    output logic       m_o
);
    e_ctrl_t e;
    wsel_e   w;
    always_comb begin
        e = '0;
        w = W_ALU;
        case (op_i)
            OP_ADD: begin e.alu = ALU_ADD; e.op2 = ~imm_i; end
            OP_AND: begin e.alu = ALU_AND; e.op2 = ~imm_i; end
            OP_NOT: begin e.alu = ALU_NOT; e.op2 = 1'b1; end
            OP_BR, OP_LD, OP_ST, OP_LDI, OP_STI, OP_LEA: begin e.pcs1 = PCS1_OFF9; e.pcs2 = 1'b1; end
            OP_LDR, OP_STR: e.pcs1 = PCS1_OFF6;
            OP_JMP: e.pcs1 = PCS1_ZERO;
            default: ;
        endcase
        w = (op_i == OP_LD || op_i == OP_LDI || op_i == OP_LDR) ? W_MEM : (op_i == OP_LEA) ? W_LEA : W_ALU;
    end
    assign e_o = e;
    assign w_o = w;
    assign m_o = (op_i == OP_LDI) || (op_i == OP_STI);
endmodule

// File: rtl/lc3_decode_stage.sv
// lc3_decode_stage: registers IR, next-PC and decoded controls; holds everything while enable_decode is low
module lc3_decode_stage
    import lc3_pkg::*;
#(
    parameter int INSTR_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable_decode,
    input  logic [INSTR_W-1:0] dout,
    input  logic [INSTR_W-1:0] npc_in,
    output logic [INSTR_W-1:0] IR,
    output logic [INSTR_W-1:0] npc_out,
    output logic [5:0]         E_control,
    output logic [1:0]         W_control,
    output logic               Mem_control
);
    if (INSTR_W != 16) begin : g_bad_width
        $error("lc3_decode_stage: INSTR_W must be 16");
    end
    logic [INSTR_W-1:0] ir_q, ir_d, npc_q, npc_d;
    logic [5:0] e_q, e_d, e_dec;
    logic [1:0] w_q, w_d, w_dec;
    logic       m_q, m_d, m_dec;
    lc3_decode_ctrl u_ctrl (
        .op_i (dout[INSTR_W-1 -: 4]),
        .imm_i(dout[5]),
        .e_o  (e_dec),
        .w_o  (w_dec),
        .m_o  (m_dec)
    );
    // a known-low enable selects the held value, so X on dout never reaches the flops
    always_comb begin
        ir_d  = enable_decode ? dout   : ir_q;
        npc_d = enable_decode ? npc_in : npc_q;
        e_d   = enable_decode ? e_dec  : e_q;
        w_d   = enable_decode ? w_dec  : w_q;
        m_d   = enable_decode ? m_dec  : m_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            ir_q  <= '0;
            npc_q <= '0;
            e_q   <= '0;
            w_q   <= '0;
            m_q   <= 1'b0;
        end else begin
            ir_q  <= ir_d;
            npc_q <= npc_d;
            e_q   <= e_d;
            w_q   <= w_d;
            m_q   <= m_d;
        end
    end
    assign IR          = ir_q;
    assign npc_out     = npc_q;
    assign E_control   = e_q;
    assign W_control   = w_q;
    assign Mem_control = m_q;
endmodule
